// File: rtl/parking_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
// Shared types and constants for the parking gate scheduler.
//   sched_state_e   : scheduler FSM state encoding
//   DIR_ENTRY/EXIT  : meaning of a gate_dir bit
//   MAX_CAP_PARKING : capacity of the occupancy core this block fronts
//   idx_width()     : index width for a gate count (at least 1 bit)
// -----------------------------------------------------------------------------
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_DENY   = 3'd2,
    ST_OPEN   = 3'd3,
    ST_COMMIT = 3'd4,
    ST_SETTLE = 3'd5,
    ST_ABORT  = 3'd6
  } sched_state_e;

  localparam logic DIR_ENTRY       = 1'b1;
  localparam logic DIR_EXIT        = 1'b0;
  localparam int   MAX_CAP_PARKING = 700;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parking_rr_arbiter.sv
// -----------------------------------------------------------------------------
// parking_rr_arbiter
// Combinational round-robin pick: returns the first asserted request at or
// after ptr, wrapping past the last gate back to gate 0.
// Ports:
//   req         in  NUM_GATES  request vector
//   ptr         in  IDX_W      gate with highest priority this round
//   grant_idx   out IDX_W      selected gate (0 when nothing is requested)
//   grant_valid out 1          at least one request present
// -----------------------------------------------------------------------------
module parking_rr_arbiter
  import parking_pkg::*;
#(
  parameter int NUM_GATES = 4,
  parameter int IDX_W     = idx_width(NUM_GATES)
) (
  input  logic [NUM_GATES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_valid
);

  // cand[k] is the gate that sits k places after ptr in priority order.
  logic [IDX_W-1:0]     cand [NUM_GATES];
  logic [NUM_GATES-1:0] hit;

  for (genvar gi = 0; gi < NUM_GATES; gi++) begin : g_cand
    assign cand[gi] = IDX_W'((int'(ptr) + gi) % NUM_GATES);
    assign hit[gi]  = req[cand[gi]];
  end

  // Scan from lowest priority to highest so the nearest hit overwrites.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int off = NUM_GATES - 1; off >= 0; off--) begin
      if (hit[off]) begin
        grant_idx   = cand[off];
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_gate_scheduler.sv
// -----------------------------------------------------------------------------
// parking_gate_scheduler
// Shares one parking occupancy core among NUM_GATES barrier gates. One request
// is served at a time (round-robin); entry needs the class vacancy flag, exit
// needs a non-zero class count. An accepted request opens the barrier until the
// passage sensor fires (commit pulse to the core) or PASS_TIMEOUT expires.
//
// Ports:
//   clk, start (async active-low reset)
//   gate_req/gate_dir/gate_is_uni/gate_passed  in  per-gate sensor side
//   uni_is_vacated_space, is_vacated_space     in  core vacancy flags
//   uni_car_parked, parked_car                 in  core counts (CNT_W)
//   car_entered/car_exited + is_uni_* quals    out commit pulses to the core
//   gate_ack/gate_deny                         out per-gate one-cycle pulses
//   gate_open                                  out barrier level, one-hot or 0
//   busy                                       out FSM not idle
// Optional (macro PARKING_SCHED_STATS_EN):
//   deny_count, timeout_count                  out saturating event counters
// -----------------------------------------------------------------------------
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int NUM_GATES    = 4,
  parameter int PASS_TIMEOUT = 16,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 start,
  input  logic [NUM_GATES-1:0] gate_req,
  input  logic [NUM_GATES-1:0] gate_dir,
  input  logic [NUM_GATES-1:0] gate_is_uni,
  input  logic [NUM_GATES-1:0] gate_passed,
  input  logic                 uni_is_vacated_space,
  input  logic                 is_vacated_space,
  input  logic [CNT_W-1:0]     uni_car_parked,
  input  logic [CNT_W-1:0]     parked_car,
  output logic                 car_entered,
  output logic                 car_exited,
  output logic                 is_uni_car_entered,
  output logic                 is_uni_car_exited,
  output logic [NUM_GATES-1:0] gate_ack,
  output logic [NUM_GATES-1:0] gate_deny,
  output logic [NUM_GATES-1:0] gate_open,
  output logic                 busy
`ifdef PARKING_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0]     deny_count,
  output logic [CNT_W-1:0]     timeout_count
`endif
);

  localparam int IDX_W   = idx_width(NUM_GATES);
  localparam int TIMER_W = $clog2(PASS_TIMEOUT + 1);

  sched_state_e         state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 dir_q;
  logic                 uni_q;
  logic [TIMER_W-1:0]   timer_q;
  logic                 car_entered_q;
  logic                 car_exited_q;
  logic                 is_uni_car_entered_q;
  logic                 is_uni_car_exited_q;
  logic [NUM_GATES-1:0] gate_ack_q;
  logic [NUM_GATES-1:0] gate_deny_q;
  logic [NUM_GATES-1:0] gate_open_q;

  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic                 check_ok_d;
  logic [IDX_W-1:0]     rr_ptr_d;
  logic [NUM_GATES-1:0] idx_onehot_d;

  parking_rr_arbiter #(
    .NUM_GATES (NUM_GATES),
    .IDX_W     (IDX_W)
  ) u_arb (
    .req         (gate_req),
    .ptr         (rr_ptr_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Admission decision against the class (uni/public) of the latched request.
  always_comb begin
    if (dir_q == DIR_ENTRY) begin
      check_ok_d = uni_q ? uni_is_vacated_space : is_vacated_space;
    end else begin
      check_ok_d = uni_q ? (uni_car_parked != '0) : (parked_car != '0);
    end
  end

  // The served gate drops to lowest priority for the next round.
  assign rr_ptr_d     = (idx_q == IDX_W'(NUM_GATES - 1)) ? '0 : idx_q + 1'b1;
  assign idx_onehot_d = {{(NUM_GATES-1){1'b0}}, 1'b1} << idx_q;

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_q              <= ST_IDLE;
      rr_ptr_q             <= '0;
      idx_q                <= '0;
      dir_q                <= 1'b0;
      uni_q                <= 1'b0;
      timer_q              <= '0;
      car_entered_q        <= 1'b0;
      car_exited_q         <= 1'b0;
      is_uni_car_entered_q <= 1'b0;
      is_uni_car_exited_q  <= 1'b0;
      gate_ack_q           <= '0;
      gate_deny_q          <= '0;
      gate_open_q          <= '0;
    end else begin
      // Pulse outputs default low; only the transitions below raise them.
      gate_ack_q           <= '0;
      gate_deny_q          <= '0;
      car_entered_q        <= 1'b0;
      car_exited_q         <= 1'b0;
      is_uni_car_entered_q <= 1'b0;
      is_uni_car_exited_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            idx_q   <= grant_idx;
            dir_q   <= gate_dir[grant_idx];
            uni_q   <= gate_is_uni[grant_idx];
            state_q <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (check_ok_d) begin
            gate_ack_q  <= idx_onehot_d;
            gate_open_q <= idx_onehot_d;
            timer_q     <= '0;
            state_q     <= ST_OPEN;
          end else begin
            gate_deny_q <= idx_onehot_d;
            state_q     <= ST_DENY;
          end
        end

        ST_DENY: begin
          rr_ptr_q <= rr_ptr_d;
          state_q  <= ST_IDLE;
        end

        ST_OPEN: begin
          // The commit pulse is raised on this edge so it is visible during
          // COMMIT, one cycle after the sensor pulse; the barrier closes with it.
          if (gate_passed[idx_q]) begin
            gate_open_q          <= '0;
            car_entered_q        <= (dir_q == DIR_ENTRY);
            car_exited_q         <= (dir_q == DIR_EXIT);
            is_uni_car_entered_q <= (dir_q == DIR_ENTRY) && uni_q;
            is_uni_car_exited_q  <= (dir_q == DIR_EXIT) && uni_q;
            state_q              <= ST_COMMIT;
          end else if (timer_q == TIMER_W'(PASS_TIMEOUT - 1)) begin
            gate_open_q <= '0;
            state_q     <= ST_ABORT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        ST_COMMIT: begin
          state_q <= ST_SETTLE;
        end

        // Quiet cycle so the core's counters/flags reflect the commit
        // before the next admission check.
        ST_SETTLE: begin
          rr_ptr_q <= rr_ptr_d;
          state_q  <= ST_IDLE;
        end

        ST_ABORT: begin
          gate_open_q <= '0;
          rr_ptr_q    <= rr_ptr_d;
          state_q     <= ST_IDLE;
        end

        default: begin
          gate_open_q <= '0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign car_entered        = car_entered_q;
  assign car_exited         = car_exited_q;
  assign is_uni_car_entered = is_uni_car_entered_q;
  assign is_uni_car_exited  = is_uni_car_exited_q;
  assign gate_ack           = gate_ack_q;
  assign gate_deny          = gate_deny_q;
  assign gate_open          = gate_open_q;
  assign busy               = (state_q != ST_IDLE);

`ifdef PARKING_SCHED_STATS_EN
  logic [CNT_W-1:0] deny_count_q;
  logic [CNT_W-1:0] timeout_count_q;

  // Saturating counters: hold at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      deny_count_q    <= '0;
      timeout_count_q <= '0;
    end else begin
      if (state_q == ST_DENY && deny_count_q != '1) begin
        deny_count_q <= deny_count_q + 1'b1;
      end
      if (state_q == ST_ABORT && timeout_count_q != '1) begin
        timeout_count_q <= timeout_count_q + 1'b1;
      end
    end
  end

  assign deny_count    = deny_count_q;
  assign timeout_count = timeout_count_q;
`endif

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// -----------------------------------------------------------------------------
// tb_parking_gate_scheduler
// Directed stimulus with a scoreboard: the driver pushes the expected gate and
// core events into a queue; a monitor on the falling edge pops and compares
// every ack/deny/commit pulse the DUT produces, and checks output invariants.
// -----------------------------------------------------------------------------
module tb_parking_gate_scheduler;

  localparam int NG    = 4;
  localparam int CNT_W = 16;

  localparam int K_ACK   = 0;
  localparam int K_DENY  = 1;
  localparam int K_ENTER = 2;
  localparam int K_EXIT  = 3;

  typedef struct {
    int kind;
    int gate;
    bit uni;
  } ev_t;

  logic             clk = 1'b0;
  logic             start = 1'b0;
  logic [NG-1:0]    gate_req = '0;
  logic [NG-1:0]    gate_dir = '0;
  logic [NG-1:0]    gate_is_uni = '0;
  logic [NG-1:0]    gate_passed = '0;
  logic             uni_is_vacated_space = 1'b0;
  logic             is_vacated_space = 1'b0;
  logic [CNT_W-1:0] uni_car_parked = '0;
  logic [CNT_W-1:0] parked_car = '0;
  logic             car_entered, car_exited, is_uni_car_entered, is_uni_car_exited;
  logic [NG-1:0]    gate_ack, gate_deny, gate_open;
  logic             busy;
`ifdef PARKING_SCHED_STATS_EN
  logic [CNT_W-1:0] deny_count, timeout_count;
`endif

  int  n_checks = 0;
  int  n_fail   = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  parking_gate_scheduler #(
    .NUM_GATES    (NG),
    .PASS_TIMEOUT (16),
    .CNT_W        (CNT_W)
  ) dut (
    .clk                  (clk),
    .start                (start),
    .gate_req             (gate_req),
    .gate_dir             (gate_dir),
    .gate_is_uni          (gate_is_uni),
    .gate_passed          (gate_passed),
    .uni_is_vacated_space (uni_is_vacated_space),
    .is_vacated_space     (is_vacated_space),
    .uni_car_parked       (uni_car_parked),
    .parked_car           (parked_car),
    .car_entered          (car_entered),
    .car_exited           (car_exited),
    .is_uni_car_entered   (is_uni_car_entered),
    .is_uni_car_exited    (is_uni_car_exited),
    .gate_ack             (gate_ack),
    .gate_deny            (gate_deny),
    .gate_open            (gate_open),
    .busy                 (busy)
`ifdef PARKING_SCHED_STATS_EN
    ,
    .deny_count           (deny_count),
    .timeout_count        (timeout_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int gate, input bit uni);
    ev_t e;
    e.kind = kind;
    e.gate = gate;
    e.uni  = uni;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int gate, input bit uni);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d gate=%0d uni=%0d expected none", kind, gate, uni);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.gate != gate || e.uni != uni) begin
        n_fail++;
        $display("FAIL event: got kind=%0d gate=%0d uni=%0d expected kind=%0d gate=%0d uni=%0d",
                 kind, gate, uni, e.kind, e.gate, e.uni);
      end else begin
        $display("[%0t] event kind=%0d gate=%0d uni=%0d ok", $time, kind, gate, uni);
      end
    end
  endtask

  // Monitor: decoupled from the driver, samples on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (start) begin
        n_checks++;
        if ((car_entered && car_exited) || !$onehot0(gate_open) ||
            (is_uni_car_entered && !car_entered) || (is_uni_car_exited && !car_exited)) begin
          n_fail++;
          $display("FAIL invariants: got open=%b ent=%b ext=%b qe=%b qx=%b expected legal combination",
                   gate_open, car_entered, car_exited, is_uni_car_entered, is_uni_car_exited);
        end
        for (int g = 0; g < NG; g++) begin
          if (gate_ack[g])  observe(K_ACK, g, 1'b0);
          if (gate_deny[g]) observe(K_DENY, g, 1'b0);
        end
        if (car_entered) observe(K_ENTER, 0, is_uni_car_entered);
        if (car_exited)  observe(K_EXIT, 0, is_uni_car_exited);
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_idle", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_open(input int g);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (gate_open[g]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("wait_open", {31'd0, ok}, 32'd1);
  endtask

  // Issue one request from idle; ack or deny must appear two edges later.
  task automatic request(input int g, input bit dir, input bit uni);
    wait_idle();
    @(posedge clk); #1;
    gate_req[g]    = 1'b1;
    gate_dir[g]    = dir;
    gate_is_uni[g] = uni;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("resp_latency", {31'd0, gate_ack[g] | gate_deny[g]}, 32'd1);
    gate_req[g] = 1'b0;
  endtask

  // Pulse the passage sensor; the commit pulse must follow one edge later.
  task automatic pass(input int g);
    wait_open(g);
    @(posedge clk); #1;
    gate_passed[g] = 1'b1;
    @(posedge clk); #1;
    gate_passed[g] = 1'b0;
    check("commit_latency", {31'd0, car_entered | car_exited}, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    start = 1'b0;
    gate_req = '0;
    gate_passed = '0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
  endtask

  initial begin
    int seq[5];
    int cnt;
    seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 3; seq[4] = 0;

    // 1. Reset
    #12;
    check("rst_pulses", {26'd0, car_entered, car_exited, is_uni_car_entered, is_uni_car_exited, busy, 1'b0}, 32'd0);
    check("rst_ack", {28'd0, gate_ack}, 32'd0);
    check("rst_deny", {28'd0, gate_deny}, 32'd0);
    check("rst_open", {28'd0, gate_open}, 32'd0);
    @(posedge clk); #1 start = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("idle_no_req", {31'd0, busy}, 32'd0);

    // 2. Entry ok, university car on gate 1
    uni_is_vacated_space = 1'b1;
    push(K_ACK, 1, 1'b0);
    push(K_ENTER, 0, 1'b1);
    request(1, 1'b1, 1'b1);
    pass(1);

    // 3. Public lot full on gate 0
    is_vacated_space = 1'b0;
    push(K_DENY, 0, 1'b0);
    request(0, 1'b1, 1'b0);
    wait_idle();
    check("full_open", {28'd0, gate_open}, 32'd0);

    // 4. Exit uni with empty count, then with 5 parked
    uni_car_parked = 16'd0;
    push(K_DENY, 2, 1'b0);
    request(2, 1'b0, 1'b1);
    uni_car_parked = 16'd5;
    push(K_ACK, 2, 1'b0);
    push(K_EXIT, 0, 1'b1);
    request(2, 1'b0, 1'b1);
    pass(2);
    wait_idle();
`ifdef PARKING_SCHED_STATS_EN
    check("deny_count", {16'd0, deny_count}, 32'd2);
`endif

    // 5. Round-robin with all gates requesting, from a fresh pointer
    do_reset();
    is_vacated_space = 1'b1;
    gate_dir = '1;
    gate_is_uni = '0;
    for (int k = 0; k < 5; k++) begin
      push(K_ACK, seq[k], 1'b0);
      push(K_ENTER, 0, 1'b0);
    end
    gate_req = '1;
    for (int k = 0; k < 5; k++) begin
      wait_open(seq[k]);
      if (k == 4) gate_req = '0;
      pass(seq[k]);
    end
    wait_idle();

    // 6. Timeout on gate 3: barrier open exactly 16 cycles, no core pulse
    push(K_ACK, 3, 1'b0);
    request(3, 1'b1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (gate_open[3]) cnt++;
      else if (cnt > 0) break;
      @(negedge clk);
    end
    check("timeout_open_cycles", cnt, 32'd16);
    wait_idle();
`ifdef PARKING_SCHED_STATS_EN
    check("timeout_count", {16'd0, timeout_count}, 32'd1);
    check("deny_count_after_rst", {16'd0, deny_count}, 32'd0);
`endif

    // 7. Reset during an open barrier closes it without a commit
    push(K_ACK, 0, 1'b0);
    request(0, 1'b1, 1'b0);
    start = 1'b0;
    #1;
    check("midrst_open", {28'd0, gate_open}, 32'd0);
    check("midrst_commit", {30'd0, car_entered, car_exited}, 32'd0);
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    repeat (3) @(negedge clk);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
